fu_muldiv_iter_unit: RTL and testbench
======================================

// Module: fu_muldiv_iter_unit
// PURPOSE
//  Iterative multiply/divide functional unit; processes STEP_WIDTH bits of the
//  operand per clock: one partial-product row (mul) or one restoring-division chunk (div).
//  Successor to the combinational share-mod slices: valid/ready handshake on both
//  sides, full double-width product, quotient+remainder, divide-by-zero handling.
//  Sits in the execute stage beside the ALU; one operation in flight at a time.
// PARAMETERS
//  DATA_WIDTH  64  operand width; must be a multiple of STEP_WIDTH
//  STEP_WIDTH  8   bits retired per BUSY cycle; NSTEP = DATA_WIDTH/STEP_WIDTH
// PORTS
//  clk        in   1           clock, all state updates on rising edge
//  rst        in   1           synchronous reset, active-high
//  in_valid   in   1           operation request
//  in_ready   out  1           unit can accept (state IDLE)
//  in_op      in   1           0 = multiply, 1 = divide
//  in_signed  in   1           operands two's complement (see CONFIGURATION)
//  in_a       in   DATA_WIDTH  multiplicand / dividend
//  in_b       in   DATA_WIDTH  multiplier / divisor
//  out_valid  out  1           result available
//  out_ready  in   1           consumer accepts result
//  out_lo     out  DATA_WIDTH  mul: product[DATA_WIDTH-1:0]; div: quotient
//  out_hi     out  DATA_WIDTH  mul: product[2*DATA_WIDTH-1:DATA_WIDTH]; div: remainder
//  out_dz     out  1           divide by zero flagged (div only, else 0)
// BEHAVIOUR
//  - Reset: state IDLE, in_ready=1, out_valid=0, out_lo=out_hi=0, out_dz=0, step counter 0.
//    rst mid-operation aborts; no result is ever produced for the aborted op.
//  - FSM IDLE -> BUSY on in_valid&&in_ready (operands latched, counter=0).
//    BUSY: one step per cycle; after step NSTEP-1 -> DONE with result registered.
//    DONE: out_valid=1, outputs stable; out_ready -> IDLE. Back-pressure holds DONE.
//  - Latency: accept edge at cycle 0 -> out_valid high in cycle NSTEP+1 (9 at defaults).
//    No new accept while BUSY/DONE (in_ready=0); in_ready returns the cycle after out handshake.
//  - Mul step k: acc += a * b[k*STEP_WIDTH +: STEP_WIDTH] << (k*STEP_WIDTH); acc is
//    2*DATA_WIDTH wide, no truncation; unsigned result exact for all inputs.
//  - Div step k: restoring division on chunk from MSB; per bit: rem=(rem<<1)|next_a_bit,
//    if rem>=b {rem-=b; q bit=1}. Quotient/remainder exact unsigned after NSTEP steps.
//  - Divide by zero (in_op=1, in_b=0): skip BUSY, IDLE -> DONE in one cycle
//    (out_valid in cycle 1); out_lo=all ones, out_hi=in_a, out_dz=1.
//  - Multiply by zero takes full NSTEP latency (no early-out).
//  - Outputs only change on the edge entering DONE or on reset.
// CONFIGURATION
//  FU_MULDIV_SIGNED_EN defined: in_signed=1 treats operands as two's complement.
//    Magnitudes latched at accept; sign fix applied when entering DONE (no extra latency).
//    mul: product negated if sign(a)^sign(b). div: quotient sign = sign(a)^sign(b),
//    remainder sign = sign(a). MIN/-1: quotient=MIN, remainder=0, no flag.
//    Signed div by zero: out_lo=all ones (-1), out_hi=in_a, out_dz=1.
//  Not defined: in_signed ignored; all ops unsigned; sign-fix logic absent.
// TESTING (DATA_WIDTH=64, STEP_WIDTH=8)
//  1 mul a=0xFFFF_FFFF_FFFF_FFFF b=0xFFFF_FFFF_FFFF_FFFF -> hi=0xFFFF_FFFF_FFFF_FFFE,
//    lo=0x0000_0000_0000_0001, out_valid exactly cycle 9 after accept.
//  2 div a=1000 b=7 -> lo=142, hi=6, out_dz=0; div a=5 b=9 -> lo=0, hi=5.
//  3 div a=0x1234 b=0 -> out_valid in cycle 1, lo=all ones, hi=0x1234, out_dz=1.
//  4 signed (macro on): div a=-7 b=2 -> lo=-3, hi=-1; mul a=-3 b=5 -> {hi,lo}=-15;
//    div a=0x8000_0000_0000_0000 b=-1 -> lo=0x8000_0000_0000_0000, hi=0.
//  5 hold out_ready=0 for 20 cycles in DONE -> outputs stable, in_ready=0, new
//    in_valid ignored; release -> in_ready=1 next cycle, back-to-back op correct.
//  6 assert rst at BUSY step 4 -> next cycle IDLE, in_ready=1, out_valid=0,
//    outputs 0; following mul 3*4 -> lo=12, hi=0.

Source files
------------

// File: rtl/fu_muldiv_iter_unit.sv
// fu_muldiv_iter_unit
//    Iterative multiply/divide unit for the execute stage. It accepts one
//    operation at a time and retires STEP_WIDTH bits of the operand per BUSY
//    cycle. Each multiply step adds one partial-product row. Each divide step
//    performs STEP_WIDTH restoring-division bits. Multiply returns the full
//    double-width product. Divide returns the quotient and the remainder.
//    A divide by zero skips BUSY and is flagged on out_dz.
//
//    Build option: define FU_MULDIV_SIGNED_EN so that in_signed=1 selects
//    two's-complement operands. In that build, magnitudes are latched at
//    accept, and the sign fix is applied on the edge that enters DONE.
//    Without the define, in_signed is ignored and every operation is unsigned.
//
// Ports
//    clk, rst             clock, synchronous active-high reset
//    in_valid / in_ready  request handshake (in_ready only while IDLE)
//    in_op                0 = multiply, 1 = divide
//    in_signed            two's-complement operands (signed build only)
//    in_a, in_b           multiplicand/dividend, multiplier/divisor
//    out_valid/out_ready  result handshake (out_valid while DONE)
//    out_lo               product low half, or quotient
//    out_hi               product high half, or remainder
//    out_dz               divide-by-zero flag
module fu_muldiv_iter_unit #(
   parameter int DATA_WIDTH = 64,
   parameter int STEP_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_op,
   input  logic                  in_signed,
   input  logic [DATA_WIDTH-1:0] in_a,
   input  logic [DATA_WIDTH-1:0] in_b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_lo,
   output logic [DATA_WIDTH-1:0] out_hi,
   output logic                  out_dz
);
   localparam int NSTEP = DATA_WIDTH / STEP_WIDTH;
   localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
   localparam int W2    = 2 * DATA_WIDTH;
   localparam logic [CW-1:0] LAST_STEP = CW'(NSTEP - 1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;
   state_t state_reg, state_next;

   logic [CW-1:0]         step_reg;
   logic                  op_reg;
   // Multiplicand, pre-shifted to the weight of the current row.
   // For a divide, its low half is the dividend, consumed MSB first.
   logic [W2-1:0]         a_reg;
   logic [DATA_WIDTH-1:0] b_reg;
   // Multiply: running product. Divide: {remainder, quotient}.
   logic [W2-1:0]         acc_reg;
   logic [DATA_WIDTH-1:0] out_lo_reg, out_hi_reg;
   logic                  out_dz_reg;

   logic accept, div_zero, last_step;
   assign accept    = (state_reg == S_IDLE) && in_valid;
   assign div_zero  = in_op && (in_b == '0);
   assign last_step = (step_reg == LAST_STEP);

   // Operand magnitudes latched at accept.
   logic [DATA_WIDTH-1:0] mag_a, mag_b;
`ifdef FU_MULDIV_SIGNED_EN
   logic neg_a, neg_b;
   logic neg_lo_reg, neg_hi_reg;
   assign neg_a = in_signed && in_a[DATA_WIDTH-1];
   assign neg_b = in_signed && in_b[DATA_WIDTH-1];
   assign mag_a = neg_a ? -in_a : in_a;
   assign mag_b = neg_b ? -in_b : in_b;
`else
   logic unused_signed;
   assign unused_signed = in_signed;
   assign mag_a = in_a;
   assign mag_b = in_b;
`endif

   // Multiply: one partial-product row per step.
   // b_reg shifts right, so its low chunk is always the current digit.
   logic [W2-1:0] mul_row;
   assign mul_row = a_reg * {{(W2-STEP_WIDTH){1'b0}}, b_reg[STEP_WIDTH-1:0]};

   // Divide: STEP_WIDTH chained restoring-division bits.
   // The remainder is always < b, so a carry out of the shift means
   // (rem<<1 | bit) >= 2^W > b. Subtracting modulo 2^W is then exact.
   logic [DATA_WIDTH-1:0] rem_chain [0:STEP_WIDTH];
   logic [STEP_WIDTH-1:0] q_bits;
   assign rem_chain[0] = acc_reg[W2-1:DATA_WIDTH];

   genvar gi;
   generate
      for (gi = 0; gi < STEP_WIDTH; gi++) begin : g_div_bit
         logic [DATA_WIDTH-1:0] shifted;
         logic                  ge;
         assign shifted = {rem_chain[gi][DATA_WIDTH-2:0], a_reg[DATA_WIDTH-1-gi]};
         assign ge      = rem_chain[gi][DATA_WIDTH-1] || (shifted >= b_reg);
         assign rem_chain[gi+1]       = ge ? (shifted - b_reg) : shifted;
         assign q_bits[STEP_WIDTH-1-gi] = ge;
      end
   endgenerate

   logic [W2-1:0] acc_step;
   assign acc_step = op_reg ? {rem_chain[STEP_WIDTH], acc_reg[DATA_WIDTH-STEP_WIDTH-1:0], q_bits}
                            : acc_reg + mul_row;

   // Final result with the sign correction applied.
   // It is only captured on the last step.
   logic [W2-1:0] result;
`ifdef FU_MULDIV_SIGNED_EN
   always_comb begin
      result = acc_step;
      if (op_reg) begin
         if (neg_hi_reg) result[W2-1:DATA_WIDTH] = -acc_step[W2-1:DATA_WIDTH];
         if (neg_lo_reg) result[DATA_WIDTH-1:0]  = -acc_step[DATA_WIDTH-1:0];
      end else if (neg_lo_reg) begin
         result = -acc_step;
      end
   end
`else
   assign result = acc_step;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_reg <= S_IDLE;
      else     state_reg <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (in_valid)  state_next = div_zero ? S_DONE : S_BUSY;
         S_BUSY:  if (last_step) state_next = S_DONE;
         S_DONE:  if (out_ready) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Handshake outputs
   always_comb begin
      in_ready  = (state_reg == S_IDLE);
      out_valid = (state_reg == S_DONE);
   end

   // Datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         step_reg   <= '0;
         op_reg     <= 1'b0;
         a_reg      <= '0;
         b_reg      <= '0;
         acc_reg    <= '0;
         out_lo_reg <= '0;
         out_hi_reg <= '0;
         out_dz_reg <= 1'b0;
`ifdef FU_MULDIV_SIGNED_EN
         neg_lo_reg <= 1'b0;
         neg_hi_reg <= 1'b0;
`endif
      end else begin
         if (accept) begin
            op_reg   <= in_op;
            a_reg    <= {{DATA_WIDTH{1'b0}}, mag_a};
            b_reg    <= mag_b;
            acc_reg  <= '0;
            step_reg <= '0;
`ifdef FU_MULDIV_SIGNED_EN
            neg_lo_reg <= neg_a ^ neg_b;
            neg_hi_reg <= neg_a;
`endif
            // Divide by zero goes straight to DONE and reports the raw dividend.
            if (div_zero) begin
               out_lo_reg <= '1;
               out_hi_reg <= in_a;
               out_dz_reg <= 1'b1;
            end
         end
         if (state_reg == S_BUSY) begin
            a_reg    <= a_reg << STEP_WIDTH;
            b_reg    <= op_reg ? b_reg : (b_reg >> STEP_WIDTH);
            acc_reg  <= acc_step;
            step_reg <= step_reg + CW'(1);
            if (last_step) begin
               out_lo_reg <= result[DATA_WIDTH-1:0];
               out_hi_reg <= result[W2-1:DATA_WIDTH];
               out_dz_reg <= 1'b0;
            end
         end
      end
   end

   assign out_lo = out_lo_reg;
   assign out_hi = out_hi_reg;
   assign out_dz = out_dz_reg;

endmodule

// File: tb/tb_fu_muldiv_iter_unit.sv
// Testbench for fu_muldiv_iter_unit at the default sizes (64-bit operands, 8-bit steps).
// At each accept, the expected result is computed by a small model and pushed to a scoreboard.
// The expected result is popped and compared when out_valid rises.
module tb_fu_muldiv_iter_unit;
   localparam int DW    = 64;
   localparam int NSTEP = 8;
`ifdef FU_MULDIV_SIGNED_EN
   localparam bit SIGNED_BUILD = 1'b1;
`else
   localparam bit SIGNED_BUILD = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst, in_valid, in_ready, in_op, in_signed;
   logic          out_valid, out_ready, out_dz;
   logic [DW-1:0] in_a, in_b, out_lo, out_hi;

   int n_checks = 0;
   int n_bad    = 0;

   typedef struct packed {
      logic [DW-1:0] lo;
      logic [DW-1:0] hi;
      logic          dz;
      logic [7:0]    lat;
   } exp_t;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   fu_muldiv_iter_unit #(.DATA_WIDTH(DW), .STEP_WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_signed (in_signed),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_lo    (out_lo),
      .out_hi    (out_hi),
      .out_dz    (out_dz)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic void model(input logic op, input logic sgn,
                                 input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 output logic [DW-1:0] lo, output logic [DW-1:0] hi,
                                 output logic dz);
      logic [2*DW-1:0] p;
      logic            use_s;
      use_s = sgn && SIGNED_BUILD;
      dz    = 1'b0;
      lo    = '0;
      hi    = '0;
      if (!op) begin
         if (use_s) p = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{b[DW-1]}}, b});
         else       p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
         lo = p[DW-1:0];
         hi = p[2*DW-1:DW];
      end else if (b == '0) begin
         lo = '1;
         hi = a;
         dz = 1'b1;
      end else if (use_s && a == {1'b1, {(DW-1){1'b0}}} && b == '1) begin
         lo = a;
         hi = '0;
      end else if (use_s) begin
         lo = $signed(a) / $signed(b);
         hi = $signed(a) % $signed(b);
      end else begin
         lo = a / b;
         hi = a % b;
      end
   endfunction

   // Drive one operation and wait for its result.
   // The result is then held for 'hold' cycles under back-pressure, and the handshake completes.
   task automatic run_op(input logic op, input logic sgn, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input int hold);
      exp_t          e;
      logic [DW-1:0] m_lo, m_hi;
      logic          m_dz;
      int            cnt;
      model(op, sgn, a, b, m_lo, m_hi, m_dz);
      e.lo  = m_lo;
      e.hi  = m_hi;
      e.dz  = m_dz;
      e.lat = m_dz ? 8'd1 : 8'(NSTEP + 1);
      @(negedge clk);
      check("in_ready_idle", 128'(in_ready), 128'(1));
      in_valid  = 1'b1;
      in_op     = op;
      in_signed = sgn;
      in_a      = a;
      in_b      = b;
      out_ready = (hold == 0);
      sb_q.push_back(e);
      cnt = 0;
      do begin
         @(negedge clk);
         in_valid = 1'b0;
         cnt++;
      end while (!out_valid && cnt < 64);
      e = sb_q.pop_front();
      check("out_valid", 128'(out_valid), 128'(1));
      check("latency", 128'(cnt), 128'(e.lat));
      check("lo", 128'(out_lo), 128'(e.lo));
      check("hi", 128'(out_hi), 128'(e.hi));
      check("dz", 128'(out_dz), 128'(e.dz));
      $display("op=%0d s=%0d a=%h b=%h -> lo=%h hi=%h dz=%0d lat=%0d",
               op, sgn, a, b, out_lo, out_hi, out_dz, cnt);
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         in_op    = ~op;
         in_a     = {$urandom, $urandom};
         in_b     = {$urandom, $urandom};
         @(negedge clk);
         check("hold_valid", 128'(out_valid), 128'(1));
         check("hold_in_ready", 128'(in_ready), 128'(0));
         check("hold_lo", 128'(out_lo), 128'(e.lo));
         check("hold_hi", 128'(out_hi), 128'(e.hi));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("post_in_ready", 128'(in_ready), 128'(1));
      check("post_out_valid", 128'(out_valid), 128'(0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic seen;
      rst = 1'b1; in_valid = 1'b0; in_op = 1'b0; in_signed = 1'b0;
      in_a = '0; in_b = '0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_in_ready", 128'(in_ready), 128'(1));
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_lo", 128'(out_lo), 128'(0));
      check("rst_hi", 128'(out_hi), 128'(0));
      check("rst_dz", 128'(out_dz), 128'(0));

      run_op(1'b0, 1'b0, '1, '1, 0);
      run_op(1'b1, 1'b0, 64'd1000, 64'd7, 0);
      run_op(1'b1, 1'b0, 64'd5, 64'd9, 0);
      run_op(1'b1, 1'b0, 64'h1234, 64'd0, 0);
      run_op(1'b1, 1'b1, -64'd7, 64'd2, 0);
      run_op(1'b0, 1'b1, -64'd3, 64'd5, 0);
      run_op(1'b1, 1'b1, 64'h8000_0000_0000_0000, '1, 0);
      run_op(1'b1, 1'b1, -64'd5, 64'd0, 0);
      run_op(1'b0, 1'b0, 64'd0, 64'hDEAD_BEEF_0BAD_F00D, 0);
      run_op(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
      run_op(1'b0, 1'b0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 20);
      run_op(1'b1, 1'b0, 64'hFEDC_BA98_7654_3210, 64'h0000_0000_0001_0003, 0);
      for (int i = 0; i < 8; i++)
         run_op(1'($urandom_range(0, 1)), 1'b0, {$urandom, $urandom},
                {$urandom, $urandom} >> $urandom_range(0, 60), 0);

      // Abort a multiply at BUSY step 4 with reset.
      @(negedge clk);
      in_valid = 1'b1; in_op = 1'b0; in_signed = 1'b0;
      in_a = 64'h55; in_b = 64'h77;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("abort_busy", 128'(in_ready), 128'(0));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_in_ready", 128'(in_ready), 128'(1));
      check("abort_out_valid", 128'(out_valid), 128'(0));
      check("abort_lo", 128'(out_lo), 128'(0));
      check("abort_hi", 128'(out_hi), 128'(0));
      check("abort_dz", 128'(out_dz), 128'(0));
      seen = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check("abort_no_result", 128'(seen), 128'(0));
      run_op(1'b0, 1'b0, 64'd3, 64'd4, 0);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end
endmodule
